// File: rtl/fsk_modulator_stream_if.sv
// Word-level valid/ready channel feeding the FSK modulator.
interface fsk_modulator_stream_if #(
  parameter int WORD_W = 14
);
  logic              word_valid;
  logic [WORD_W-1:0] word_in;
  logic              word_ready;

  modport master (output word_valid, output word_in, input word_ready);
  modport slave  (input word_valid, input word_in, output word_ready);
endinterface

// File: rtl/fsk_modulator_stream.sv
// Binary-FSK modulator: serialises a codeword and emits a square-wave tone per bit,
// fast tone for mark ('1'), slow tone for space ('0'), with gapless word streaming.
module fsk_modulator_stream #(
  parameter int WORD_W          = 14,
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DIV_MARK        = 1,
  parameter int DIV_SPACE       = 2,
  parameter int MSB_FIRST       = 0,
  localparam int BIDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic                   FSK_clk,
  input  logic                   reset_n,
  fsk_modulator_stream_if.slave  word_if,
  output logic                   fsk,
  output logic                   busy,
  output logic                   bit_out,
  output logic [BIDX_W-1:0]      bit_idx,
  output logic                   frame_done
);

  localparam int SCNT_W  = $clog2(SAMPLES_PER_BIT);
  localparam int DIV_MAX = (DIV_MARK > DIV_SPACE) ? DIV_MARK : DIV_SPACE;
  localparam int TCNT_W  = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                fsk_q, fsk_d;
  logic                frame_done_q, frame_done_d;

  logic [BIDX_W-1:0]   sel;
  logic                cur_bit;
  logic [TCNT_W-1:0]   div_last;
  logic                bit_end;
  logic                last_sample;
  logic                ready;

  // Bit selection and tone divider limit for the bit currently on air.
  always_comb begin
    sel         = (MSB_FIRST != 0) ? (BIDX_W'(WORD_W - 1) - bidx_q) : bidx_q;
    cur_bit     = word_q[sel];
    div_last    = cur_bit ? TCNT_W'(DIV_MARK - 1) : TCNT_W'(DIV_SPACE - 1);
    bit_end     = (scnt_q == SCNT_W'(SAMPLES_PER_BIT - 1));
    last_sample = bit_end && (bidx_q == BIDX_W'(WORD_W - 1));
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    scnt_d       = scnt_q;
    bidx_d       = bidx_q;
    tcnt_d       = tcnt_q;
    fsk_d        = fsk_q;
    frame_done_d = 1'b0;
    ready        = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (word_if.word_valid) begin
          word_d  = word_if.word_in;
          scnt_d  = '0;
          bidx_d  = '0;
          tcnt_d  = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (tcnt_q == div_last) begin
          fsk_d  = ~fsk_q;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end

        // The tone phase carries across bit and word boundaries; only the divider restarts.
        if (bit_end) begin
          scnt_d = '0;
          tcnt_d = '0;
          if (last_sample) begin
            ready        = 1'b1;
            frame_done_d = 1'b1;
            bidx_d       = '0;
            if (word_if.word_valid) begin
              word_d  = word_if.word_in;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge FSK_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      scnt_q       <= '0;
      bidx_q       <= '0;
      tcnt_q       <= '0;
      fsk_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      scnt_q       <= scnt_d;
      bidx_q       <= bidx_d;
      tcnt_q       <= tcnt_d;
      fsk_q        <= fsk_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign word_if.word_ready = ready;
  assign fsk        = fsk_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == SEND);
  assign bit_out    = busy && cur_bit;
  assign bit_idx    = busy ? bidx_q : '0;

endmodule

// File: tb/tb_fsk_modulator_stream.sv
// Directed bench for fsk_modulator_stream: LSB-first default instance plus an
// MSB-first instance, with toggle counting and handshake/frame checks per word.
module tb_fsk_modulator_stream;

  logic        clk;
  logic        resetN;
  logic        sel;
  logic        validIn;
  logic [13:0] wordIn;

  logic        fsk0, busy0, bitOut0, fd0;
  logic [3:0]  idx0;
  logic        fsk1, busy1, bitOut1, fd1;
  logic [3:0]  idx1;

  logic        obsFsk, obsBusy, obsBitOut, obsFd, obsReady;
  logic [3:0]  obsIdx;

  int checks = 0;
  int errors = 0;

  int toggles, togFirst16, busyCnt, readyCnt, fdCnt, fdFirst, fdLast;
  int idxErr, markCnt, mark13;
  logic bitAt1, bitAt225, endBusy, endReady;

  fsk_modulator_stream_if #(.WORD_W(14)) if0 ();
  fsk_modulator_stream_if #(.WORD_W(14)) if1 ();

  assign if0.word_valid = !sel && validIn;
  assign if0.word_in    = wordIn;
  assign if1.word_valid = sel && validIn;
  assign if1.word_in    = wordIn;

  fsk_modulator_stream #(.WORD_W(14), .SAMPLES_PER_BIT(16), .DIV_MARK(1), .DIV_SPACE(2), .MSB_FIRST(0)) dut0 (
    .FSK_clk    (clk),
    .reset_n    (resetN),
    .word_if    (if0.slave),
    .fsk        (fsk0),
    .busy       (busy0),
    .bit_out    (bitOut0),
    .bit_idx    (idx0),
    .frame_done (fd0)
  );

  fsk_modulator_stream #(.WORD_W(14), .SAMPLES_PER_BIT(16), .DIV_MARK(1), .DIV_SPACE(2), .MSB_FIRST(1)) dut1 (
    .FSK_clk    (clk),
    .reset_n    (resetN),
    .word_if    (if1.slave),
    .fsk        (fsk1),
    .busy       (busy1),
    .bit_out    (bitOut1),
    .bit_idx    (idx1),
    .frame_done (fd1)
  );

  assign obsFsk    = sel ? fsk1 : fsk0;
  assign obsBusy   = sel ? busy1 : busy0;
  assign obsBitOut = sel ? bitOut1 : bitOut0;
  assign obsFd     = sel ? fd1 : fd0;
  assign obsIdx    = sel ? idx1 : idx0;
  assign obsReady  = sel ? if1.word_ready : if0.word_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge with the word already presented; acceptance happens on the
  // next rising edge and cycle i is observed at the i-th following falling edge.
  task automatic applyStimulus(input int nCyc, input int dropAt, input int changeAt, input logic [13:0] newWord);
    logic prevFsk;
    toggles = 0; togFirst16 = 0; busyCnt = 0; readyCnt = 0; fdCnt = 0;
    fdFirst = -1; fdLast = -1; idxErr = 0; markCnt = 0; mark13 = 0;
    bitAt1 = 1'bx; bitAt225 = 1'bx; endBusy = 1'bx; endReady = 1'bx;
    prevFsk = obsFsk;
    for (int i = 1; i <= nCyc; i++) begin
      @(negedge clk);
      if (obsFsk !== prevFsk) begin
        toggles++;
        if (i <= 17) togFirst16++;
      end
      prevFsk = obsFsk;
      if (i < nCyc) begin
        busyCnt  += int'(obsBusy);
        readyCnt += int'(obsReady);
        markCnt  += int'(obsBitOut);
        if (obsBitOut && obsIdx == 4'd13) mark13++;
        if (obsIdx !== 4'(((i - 1) % 224) / 16)) idxErr++;
      end
      if (obsFd) begin
        fdCnt++;
        if (fdFirst < 0) fdFirst = i;
        fdLast = i;
      end
      if (i == 1)   bitAt1 = obsBitOut;
      if (i == 225) bitAt225 = obsBitOut;
      if (i == nCyc) begin
        endBusy  = obsBusy;
        endReady = obsReady;
      end
      if (i == dropAt)   validIn = 1'b0;
      if (i == changeAt) wordIn = newWord;
    end
  endtask

  initial begin
    sel     = 1'b0;
    resetN  = 1'b0;
    validIn = 1'b1;
    wordIn  = 14'h3FFF;

    #2;
    checkOutput("rst_fsk", obsFsk, 0);
    checkOutput("rst_busy", obsBusy, 0);
    checkOutput("rst_frame_done", obsFd, 0);
    checkOutput("rst_ready", obsReady, 1);
    checkOutput("rst_bit_out", obsBitOut, 0);
    checkOutput("rst_bit_idx", obsIdx, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_hold_busy", obsBusy, 0);
    checkOutput("rst_hold_fsk", obsFsk, 0);

    $display("[TB] all-mark word 3FFF");
    resetN = 1'b1;
    applyStimulus(225, 1, 0, 14'h0);
    checkOutput("3fff_toggles", toggles, 224);
    checkOutput("3fff_fsk_end", obsFsk, 0);
    checkOutput("3fff_busy_cycles", busyCnt, 224);
    checkOutput("3fff_ready_cycles", readyCnt, 1);
    checkOutput("3fff_fd_count", fdCnt, 1);
    checkOutput("3fff_fd_cycle", fdFirst, 225);
    checkOutput("3fff_mark_cycles", markCnt, 224);
    checkOutput("3fff_idx_errs", idxErr, 0);
    checkOutput("3fff_end_busy", endBusy, 0);
    checkOutput("3fff_end_ready", endReady, 1);

    $display("[TB] all-space word 0000");
    validIn = 1'b1;
    wordIn  = 14'h0000;
    applyStimulus(225, 1, 0, 14'h0);
    checkOutput("0000_toggles", toggles, 112);
    checkOutput("0000_first16_toggles", togFirst16, 8);
    checkOutput("0000_mark_cycles", markCnt, 0);
    checkOutput("0000_idx_errs", idxErr, 0);
    checkOutput("0000_fsk_end", obsFsk, 0);
    checkOutput("0000_fd_cycle", fdFirst, 225);

    $display("[TB] back-to-back 2AAA then 1555");
    validIn = 1'b1;
    wordIn  = 14'h2AAA;
    applyStimulus(449, 225, 1, 14'h1555);
    checkOutput("b2b_toggles", toggles, 336);
    checkOutput("b2b_busy_cycles", busyCnt, 448);
    checkOutput("b2b_fd_count", fdCnt, 2);
    checkOutput("b2b_fd_first", fdFirst, 225);
    checkOutput("b2b_fd_last", fdLast, 449);
    checkOutput("b2b_ready_cycles", readyCnt, 2);
    checkOutput("b2b_idx_errs", idxErr, 0);
    checkOutput("b2b_mark_cycles", markCnt, 224);
    checkOutput("b2b_first_bit_w1", bitAt1, 0);
    checkOutput("b2b_first_bit_w2", bitAt225, 1);
    checkOutput("b2b_end_busy", endBusy, 0);

    $display("[TB] async reset at bit 5 sample 7");
    validIn = 1'b1;
    wordIn  = 14'h0000;
    applyStimulus(88, 1, 0, 14'h0);
    checkOutput("mid_toggles", toggles, 43);
    checkOutput("mid_fsk_before", obsFsk, 1);
    checkOutput("mid_idx_before", obsIdx, 5);
    resetN = 1'b0;
    #1;
    checkOutput("mid_fsk_after", obsFsk, 0);
    checkOutput("mid_busy_after", obsBusy, 0);
    checkOutput("mid_idx_after", obsIdx, 0);
    checkOutput("mid_fd_after", obsFd, 0);
    validIn = 1'b1;
    wordIn  = 14'h0001;
    repeat (2) @(negedge clk);
    checkOutput("mid_fd_held", obsFd, 0);
    resetN = 1'b1;
    applyStimulus(225, 1, 0, 14'h0);
    checkOutput("lsb0001_toggles", toggles, 120);
    checkOutput("lsb0001_first16_toggles", togFirst16, 16);
    checkOutput("lsb0001_mark_cycles", markCnt, 16);
    checkOutput("lsb0001_first_bit", bitAt1, 1);
    checkOutput("lsb0001_idx_errs", idxErr, 0);
    checkOutput("lsb0001_fd_count", fdCnt, 1);
    checkOutput("lsb0001_fd_cycle", fdFirst, 225);

    $display("[TB] MSB-first instance word 0001");
    sel     = 1'b1;
    validIn = 1'b1;
    wordIn  = 14'h0001;
    applyStimulus(225, 1, 0, 14'h0);
    checkOutput("msb0001_toggles", toggles, 120);
    checkOutput("msb0001_first16_toggles", togFirst16, 8);
    checkOutput("msb0001_mark_cycles", markCnt, 16);
    checkOutput("msb0001_mark_at_13", mark13, 16);
    checkOutput("msb0001_first_bit", bitAt1, 0);
    checkOutput("msb0001_fd_cycle", fdFirst, 225);
    checkOutput("msb0001_end_busy", endBusy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_modulator_stream.md
Name: fsk_modulator_stream

Overview:
Parametrised binary-FSK modulator with a valid/ready word interface. It accepts a WORD_W-bit codeword (e.g. a Hamming-encoded word), serialises it LSB- or MSB-first, and emits one square-wave tone per bit: a fast tone for '1' (mark) and a slower tone for '0' (space). Each bit lasts SAMPLES_PER_BIT clocks. Words may be streamed back-to-back with no gap; a completion pulse and a current-bit debug tap are provided. It sits between the channel encoder and the line/demodulator loopback.

Parameters:
WORD_W, 14, codeword width in bits (>=1)
SAMPLES_PER_BIT, 16, clocks per transmitted bit (>=2)
DIV_MARK, 1, fsk toggles once every DIV_MARK clocks while sending '1' (>=1)
DIV_SPACE, 2, fsk toggles once every DIV_SPACE clocks while sending '0' (>=1)
MSB_FIRST, 0, 0 = send bit 0 first; 1 = send bit WORD_W-1 first

Ports:
FSK_clk  in  1  sample clock; all state updates on its rising edge
reset_n  in  1  asynchronous, active-low reset
word_valid  in  1  word_in holds a word to send
word_in  in  WORD_W  codeword
word_ready  out  1  block accepts word_in this cycle
fsk  out  1  modulated output, registered
busy  out  1  high while a word is being sent
bit_out  out  1  data bit currently being modulated (0 when idle)
bit_idx  out  max(1,$clog2(WORD_W))  position in word of current bit (0 = first sent)
frame_done  out  1  one-cycle pulse after the last sample of each word

Behaviour:
- Reset (reset_n low, async): state=IDLE, fsk=0, busy=0, bit_out=0, bit_idx=0, frame_done=0, all counters 0, shift register 0. word_ready is combinational: 1 in IDLE.
- Counters: scnt 0..SAMPLES_PER_BIT-1 (samples in the bit); bidx 0..WORD_W-1; tcnt 0..max(DIV)-1 (tone divider).
- IDLE: word_ready=1. On word_valid&&word_ready: capture word_in, scnt=bidx=tcnt=0, go SEND. The first sample cycle is the cycle after acceptance. fsk holds its last level in IDLE.
- SEND, per cycle: div = cur_bit ? DIV_MARK : DIV_SPACE. If tcnt==div-1: fsk toggles, tcnt=0; else tcnt++. cur_bit = word[bidx] (MSB_FIRST=0) or word[WORD_W-1-bidx] (MSB_FIRST=1). bit_out=cur_bit, bit_idx=bidx, busy=1.
- Bit boundary (scnt==SAMPLES_PER_BIT-1): scnt=0, bidx++, tcnt=0. The fsk level carries over, so the phase is continuous and there is no extra toggle at the boundary.
- Last sample (scnt==SPB-1 && bidx==WORD_W-1): word_ready=1 in this cycle only (it is 0 in all other SEND cycles). frame_done is registered high in the following cycle.
  - If word_valid is high: capture the new word, reset the counters, stay in SEND. The next cycle is sample 0 of the new word; busy stays 1 and there is no gap.
  - Otherwise go to IDLE. busy, bit_out and bit_idx are 0 from the next cycle.
- Word-level handshake only: word_in is sampled only on acceptance, and later changes have no effect. word_valid without word_ready is held off; nothing is dropped.
- Toggles per bit = floor(SPB/div).
- Reset mid-word: the current word is abandoned, fsk goes to 0 immediately, and no frame_done is issued.
- Arithmetic: counters wrap only by explicit compare. No parameter combination produces an out-of-range bidx.

Test Plan:
- Reset: hold reset_n=0 with word_valid=1 -> fsk=0, busy=0, frame_done=0, word_ready=1; release -> word accepted on the first edge.
- Defaults, send 14'h3FFF -> 16 toggles per bit, 224 total; fsk ends at 0; busy high for 224 cycles; frame_done high in cycle 225 after acceptance; word_ready low throughout except the last sample cycle.
- Defaults, send 14'h0000 -> toggle on every 2nd clock, 8 per bit, 112 total; bit_out=0, bit_idx counts 0..13 in 16-cycle steps.
- Send 14'h0001: MSB_FIRST=0 -> first 16 cycles toggle every clock, the rest every 2nd, 120 toggles. MSB_FIRST=1 -> the mark is in the last 16 cycles; bit_out=1 only at bit_idx=13.
- Back-to-back: word_valid held high with 14'h2AAA then 14'h1555 -> second word starts the cycle after the first's last sample; busy never drops; frame_done pulses exactly 224 cycles apart; fsk shows no double toggle at any boundary.
- Async reset mid-word: pull reset_n low at bit 5, sample 7 -> fsk=0 and busy=0 without a clock edge; no frame_done; the next word restarts at bit_idx=0.
